control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock (only the halt latch uses it).
REQ-002 SHALL have reset input 1, asynchronous, active-low.
REQ-003 SHALL have opcode input 6, instruction opcode field.
REQ-004 SHALL have these 1-bit outputs: DataPCSel (write PC+4 to register file), RegSelect (1 = destination r31), RegWrite, MemRead, MemWrite, MemtoReg (1 = load data to register), AdSel (1 = branch target from register), unconditional (1 = unconditional branch), halt.
REQ-005 SHALL have conditional output 3, branch condition code.
REQ-006 SHALL have ALUop output 3, ALU operation.
REQ-007 SHALL have ALUinSel output 2, ALU B-operand source.

Function
REQ-008 SHALL decode all outputs except halt combinationally from opcode, with zero-cycle latency.
REQ-009 SHALL use ALUop encodings 000 ADD, 001 COMP (two's-complement negate), 010 AND, 011 XOR, 100 SLL, 101 SRL, 110 SRA, 111 DIFF.
REQ-010 SHALL use ALUinSel encodings 00 register rt, 01 sign-extended immediate, 10 shamt field, 11 unused (never driven).
REQ-011 SHALL use conditional encodings 000 none, 001 BLTZ, 010 BZ, 011 BNZ, 100 BCY, 101 BNCY; 110 and 111 are never driven.
REQ-012 SHALL decode register ALU ops, all with RegWrite=1 and ALUinSel=00, all other outputs 0: 000000 ADD, 000001 COMP, 000010 AND, 000011 XOR, 000100 DIFF, 000111 SHLLV (ALUop 100), 001000 SHRLV (101), 001010 SHRAV (110).
REQ-013 SHALL decode immediate-shift ops with RegWrite=1 and ALUinSel=10: 000101 SHLL (100), 000110 SHRL (101), 001001 SHRA (110).
REQ-014 SHALL decode 001011 ADDI as RegWrite=1, ALUinSel=01, ALUop=000.
REQ-015 SHALL decode 001100 COMPI as RegWrite=1, ALUinSel=01, ALUop=001.
REQ-016 SHALL decode 001101 LW as RegWrite=1, MemRead=1, MemtoReg=1, ALUinSel=01, ALUop=000.
REQ-017 SHALL decode 001110 SW as MemWrite=1, ALUinSel=01, ALUop=000, RegWrite=0.
REQ-018 SHALL decode 001111 B as unconditional=1, AdSel=0.
REQ-019 SHALL decode 010000 BR as unconditional=1, AdSel=1.
REQ-020 SHALL decode 010001 BL as unconditional=1, AdSel=0, RegWrite=1, RegSelect=1, DataPCSel=1.
REQ-021 SHALL decode 010010-010110 (BLTZ, BZ, BNZ, BCY, BNCY) as conditional 001-101 respectively, with all write/memory outputs 0.
REQ-022 SHALL decode 111111 HALT as no writes plus the halt behaviour of REQ-023.
REQ-023 SHALL drive halt = halt_q OR (opcode==111111); halt_q sets on a rising clk edge while opcode==111111, stays set regardless of later opcodes, and clears only on reset.
REQ-024 SHALL drive every output to 0 (NOP) for any unlisted opcode; ALUop and ALUinSel default to 000 and 00.
REQ-025 SHALL never assert MemRead and MemWrite together, nor unconditional together with a nonzero conditional.

Reset
REQ-026 SHALL, while reset=0, clear halt_q immediately and force every output, including combinational decode, to 0 regardless of opcode.
REQ-027 SHALL resume decoding combinationally on reset release; halt_q SHALL remain 0 until the next qualifying clk edge.

Structure
REQ-028 SHALL take opcode, ALUop, ALUinSel and conditional encodings as named constants from a shared package kgp_pkg, also used by the datapath.
REQ-029 SHALL be a single module with no sub-modules: one combinational decode block plus one async-reset flop for halt_q.

Verification
REQ-030 SHALL check: reset=1, opcode=000001 -> ALUinSel=00, ALUop=001, RegWrite=1, all others 0.
REQ-031 SHALL check: opcode=001101 (LW) -> RegWrite=MemRead=MemtoReg=1, ALUinSel=01, ALUop=000, MemWrite=0.
REQ-032 SHALL check: opcode=010001 (BL) -> unconditional=1, RegSelect=1, DataPCSel=1, RegWrite=1; opcode=010011 -> conditional=010, unconditional=0.
REQ-033 SHALL check: opcode=111111, clk edge, then opcode=000000 -> halt stays 1; reset=0 -> halt=0 asynchronously.
REQ-034 SHALL check: reset=0 with opcode=001110 -> all outputs 0; opcode=101010 with reset=1 -> all outputs 0.

Source files
------------

// File: rtl/kgp_pkg.sv
// kgp_pkg: encodings shared by the KGP control unit and datapath.
//   OP_*    : 6-bit instruction opcodes
//   ALU_*   : 3-bit ALU operation select
//   ALUIN_* : 2-bit ALU B-operand source select (2'b11 is never driven)
//   COND_*  : 3-bit branch condition code (3'b110/3'b111 are never driven)
package kgp_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_COMP  = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_XOR   = 6'b000011;
  localparam logic [5:0] OP_DIFF  = 6'b000100;
  localparam logic [5:0] OP_SHLL  = 6'b000101;
  localparam logic [5:0] OP_SHRL  = 6'b000110;
  localparam logic [5:0] OP_SHLLV = 6'b000111;
  localparam logic [5:0] OP_SHRLV = 6'b001000;
  localparam logic [5:0] OP_SHRA  = 6'b001001;
  localparam logic [5:0] OP_SHRAV = 6'b001010;
  localparam logic [5:0] OP_ADDI  = 6'b001011;
  localparam logic [5:0] OP_COMPI = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b001101;
  localparam logic [5:0] OP_SW    = 6'b001110;
  localparam logic [5:0] OP_B     = 6'b001111;
  localparam logic [5:0] OP_BR    = 6'b010000;
  localparam logic [5:0] OP_BL    = 6'b010001;
  localparam logic [5:0] OP_BLTZ  = 6'b010010;
  localparam logic [5:0] OP_BZ    = 6'b010011;
  localparam logic [5:0] OP_BNZ   = 6'b010100;
  localparam logic [5:0] OP_BCY   = 6'b010101;
  localparam logic [5:0] OP_BNCY  = 6'b010110;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_COMP = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_SRA  = 3'b110;
  localparam logic [2:0] ALU_DIFF = 3'b111;

  localparam logic [1:0] ALUIN_RT    = 2'b00;
  localparam logic [1:0] ALUIN_IMM   = 2'b01;
  localparam logic [1:0] ALUIN_SHAMT = 2'b10;

  localparam logic [2:0] COND_NONE = 3'b000;
  localparam logic [2:0] COND_BLTZ = 3'b001;
  localparam logic [2:0] COND_BZ   = 3'b010;
  localparam logic [2:0] COND_BNZ  = 3'b011;
  localparam logic [2:0] COND_BCY  = 3'b100;
  localparam logic [2:0] COND_BNCY = 3'b101;

endpackage

// File: rtl/control_unit.sv
// control_unit: combinational instruction decoder for the KGP processor,
// plus a sticky halt latch.
//   clk           : rising-edge clock, only clocks the halt latch
//   reset         : asynchronous active-low reset; forces every output to 0
//   opcode[5:0]   : instruction opcode field
//   DataPCSel     : write PC+4 to the register file
//   RegSelect     : destination register is r31
//   RegWrite      : register file write enable
//   MemRead       : data memory read
//   MemWrite      : data memory write
//   MemtoReg      : load data goes to the register file
//   AdSel         : branch target comes from a register
//   unconditional : unconditional branch
//   conditional   : branch condition code
//   ALUop         : ALU operation
//   ALUinSel      : ALU B-operand source
//   halt          : processor halted (HALT opcode now or latched earlier)
module control_unit
  import kgp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       DataPCSel,
  output logic       RegSelect,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       AdSel,
  output logic       unconditional,
  output logic [2:0] conditional,
  output logic [2:0] ALUop,
  output logic [1:0] ALUinSel,
  output logic       halt
);

  logic r_halt_q;
  logic w_is_halt;

  assign w_is_halt = (opcode == OP_HALT);

  // Sticky halt: once HALT is seen on a clock edge only reset can clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_halt_q <= 1'b0;
    end else if (w_is_halt) begin
      r_halt_q <= 1'b1;
    end
  end

  // The combinational HALT term lets halt rise in the same cycle the
  // opcode appears; the reset term masks it while reset is held.
  assign halt = reset & (r_halt_q | w_is_halt);

  always_comb begin
    DataPCSel     = 1'b0;
    RegSelect     = 1'b0;
    RegWrite      = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    AdSel         = 1'b0;
    unconditional = 1'b0;
    conditional   = COND_NONE;
    ALUop         = ALU_ADD;
    ALUinSel      = ALUIN_RT;

    case (opcode)
      OP_ADD:   begin RegWrite = 1'b1; ALUop = ALU_ADD;  end
      OP_COMP:  begin RegWrite = 1'b1; ALUop = ALU_COMP; end
      OP_AND:   begin RegWrite = 1'b1; ALUop = ALU_AND;  end
      OP_XOR:   begin RegWrite = 1'b1; ALUop = ALU_XOR;  end
      OP_DIFF:  begin RegWrite = 1'b1; ALUop = ALU_DIFF; end
      OP_SHLLV: begin RegWrite = 1'b1; ALUop = ALU_SLL;  end
      OP_SHRLV: begin RegWrite = 1'b1; ALUop = ALU_SRL;  end
      OP_SHRAV: begin RegWrite = 1'b1; ALUop = ALU_SRA;  end
      OP_SHLL:  begin RegWrite = 1'b1; ALUop = ALU_SLL; ALUinSel = ALUIN_SHAMT; end
      OP_SHRL:  begin RegWrite = 1'b1; ALUop = ALU_SRL; ALUinSel = ALUIN_SHAMT; end
      OP_SHRA:  begin RegWrite = 1'b1; ALUop = ALU_SRA; ALUinSel = ALUIN_SHAMT; end
      OP_ADDI:  begin RegWrite = 1'b1; ALUop = ALU_ADD;  ALUinSel = ALUIN_IMM; end
      OP_COMPI: begin RegWrite = 1'b1; ALUop = ALU_COMP; ALUinSel = ALUIN_IMM; end
      OP_LW: begin
        RegWrite = 1'b1;
        MemRead  = 1'b1;
        MemtoReg = 1'b1;
        ALUinSel = ALUIN_IMM;
      end
      OP_SW: begin
        MemWrite = 1'b1;
        ALUinSel = ALUIN_IMM;
      end
      OP_B:  unconditional = 1'b1;
      OP_BR: begin unconditional = 1'b1; AdSel = 1'b1; end
      OP_BL: begin
        // Branch-and-link: PC+4 is written to r31.
        unconditional = 1'b1;
        RegWrite      = 1'b1;
        RegSelect     = 1'b1;
        DataPCSel     = 1'b1;
      end
      OP_BLTZ: conditional = COND_BLTZ;
      OP_BZ:   conditional = COND_BZ;
      OP_BNZ:  conditional = COND_BNZ;
      OP_BCY:  conditional = COND_BCY;
      OP_BNCY: conditional = COND_BNCY;
      default: ;
    endcase

    // Reset overrides the decode, not just the halt latch.
    if (!reset) begin
      DataPCSel     = 1'b0;
      RegSelect     = 1'b0;
      RegWrite      = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      MemtoReg      = 1'b0;
      AdSel         = 1'b0;
      unconditional = 1'b0;
      conditional   = COND_NONE;
      ALUop         = ALU_ADD;
      ALUinSel      = ALUIN_RT;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       DataPCSel, RegSelect, RegWrite, MemRead, MemWrite, MemtoReg;
  logic       AdSel, unconditional, halt;
  logic [2:0] conditional;
  logic [2:0] ALUop;
  logic [1:0] ALUinSel;

  control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .DataPCSel    (DataPCSel),
    .RegSelect    (RegSelect),
    .RegWrite     (RegWrite),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemtoReg     (MemtoReg),
    .AdSel        (AdSel),
    .unconditional(unconditional),
    .conditional  (conditional),
    .ALUop        (ALUop),
    .ALUinSel     (ALUinSel),
    .halt         (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of all outputs: {flags[8:0], conditional, ALUop, ALUinSel}
  logic [16:0] got;
  assign got = {DataPCSel, RegSelect, RegWrite, MemRead, MemWrite, MemtoReg,
                AdSel, unconditional, halt, conditional, ALUop, ALUinSel};

  localparam logic [8:0] F_DPC = 9'h100;
  localparam logic [8:0] F_RS  = 9'h080;
  localparam logic [8:0] F_RW  = 9'h040;
  localparam logic [8:0] F_MR  = 9'h020;
  localparam logic [8:0] F_MW  = 9'h010;
  localparam logic [8:0] F_MTR = 9'h008;
  localparam logic [8:0] F_AD  = 9'h004;
  localparam logic [8:0] F_UNC = 9'h002;
  localparam logic [8:0] F_HLT = 9'h001;

  function automatic logic [16:0] pk(input logic [8:0] f, input logic [2:0] c,
                                     input logic [2:0] a, input logic [1:0] s);
    return {f, c, a, s};
  endfunction

  int tests;
  int fails;

  task automatic check(input string name, input logic [16:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: opcode=%b reset=%b got=%h expected=%h", name, opcode, reset, got, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[27];

  // Reference decode table: 64 entries, non-halt outputs only.
  logic [16:0] tab[64];
  logic        mh;   // model of the sticky halt state

  task automatic build_model();
    logic [5:0] rops[8];
    logic [2:0] raluop[8];
    logic [5:0] sops[3];
    logic [2:0] saluop[3];
    for (int i = 0; i < 64; i++) tab[i] = '0;
    rops   = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd7, 6'd8, 6'd10};
    raluop = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd4, 3'd5, 3'd6};
    for (int i = 0; i < 8; i++) tab[rops[i]] = pk(F_RW, 3'd0, raluop[i], 2'd0);
    sops   = '{6'd5, 6'd6, 6'd9};
    saluop = '{3'd4, 3'd5, 3'd6};
    for (int i = 0; i < 3; i++) tab[sops[i]] = pk(F_RW, 3'd0, saluop[i], 2'd2);
    tab[11] = pk(F_RW, 3'd0, 3'd0, 2'd1);
    tab[12] = pk(F_RW, 3'd0, 3'd1, 2'd1);
    tab[13] = pk(F_RW | F_MR | F_MTR, 3'd0, 3'd0, 2'd1);
    tab[14] = pk(F_MW, 3'd0, 3'd0, 2'd1);
    tab[15] = pk(F_UNC, 3'd0, 3'd0, 2'd0);
    tab[16] = pk(F_UNC | F_AD, 3'd0, 3'd0, 2'd0);
    tab[17] = pk(F_UNC | F_RW | F_RS | F_DPC, 3'd0, 3'd0, 2'd0);
    for (int i = 0; i < 5; i++) tab[18 + i] = pk(9'h0, 3'(i + 1), 3'd0, 2'd0);
  endtask

  function automatic logic [16:0] model_out(input logic r, input logic [5:0] op);
    logic [16:0] e;
    if (!r) return '0;
    e = tab[op];
    if (mh || op == 6'h3F) e[8] = 1'b1;
    return e;
  endfunction

  initial begin
    tests  = 0;
    fails  = 0;
    reset  = 1'b0;
    opcode = 6'b000000;
    mh     = 1'b0;
    build_model();

    vecs[0]  = '{1'b0, 6'b000000, pk(9'h0, 3'd0, 3'd0, 2'd0), "reset_state"};
    vecs[1]  = '{1'b0, 6'b001110, pk(9'h0, 3'd0, 3'd0, 2'd0), "reset_masks_sw"};
    vecs[2]  = '{1'b1, 6'b000000, pk(F_RW, 3'd0, 3'd0, 2'd0), "add"};
    vecs[3]  = '{1'b1, 6'b000001, pk(F_RW, 3'd0, 3'd1, 2'd0), "comp"};
    vecs[4]  = '{1'b1, 6'b000010, pk(F_RW, 3'd0, 3'd2, 2'd0), "and"};
    vecs[5]  = '{1'b1, 6'b000011, pk(F_RW, 3'd0, 3'd3, 2'd0), "xor"};
    vecs[6]  = '{1'b1, 6'b000100, pk(F_RW, 3'd0, 3'd7, 2'd0), "diff"};
    vecs[7]  = '{1'b1, 6'b000111, pk(F_RW, 3'd0, 3'd4, 2'd0), "shllv"};
    vecs[8]  = '{1'b1, 6'b001000, pk(F_RW, 3'd0, 3'd5, 2'd0), "shrlv"};
    vecs[9]  = '{1'b1, 6'b001010, pk(F_RW, 3'd0, 3'd6, 2'd0), "shrav"};
    vecs[10] = '{1'b1, 6'b000101, pk(F_RW, 3'd0, 3'd4, 2'd2), "shll"};
    vecs[11] = '{1'b1, 6'b000110, pk(F_RW, 3'd0, 3'd5, 2'd2), "shrl"};
    vecs[12] = '{1'b1, 6'b001001, pk(F_RW, 3'd0, 3'd6, 2'd2), "shra"};
    vecs[13] = '{1'b1, 6'b001011, pk(F_RW, 3'd0, 3'd0, 2'd1), "addi"};
    vecs[14] = '{1'b1, 6'b001100, pk(F_RW, 3'd0, 3'd1, 2'd1), "compi"};
    vecs[15] = '{1'b1, 6'b001101, pk(F_RW | F_MR | F_MTR, 3'd0, 3'd0, 2'd1), "lw"};
    vecs[16] = '{1'b1, 6'b001110, pk(F_MW, 3'd0, 3'd0, 2'd1), "sw"};
    vecs[17] = '{1'b1, 6'b001111, pk(F_UNC, 3'd0, 3'd0, 2'd0), "b"};
    vecs[18] = '{1'b1, 6'b010000, pk(F_UNC | F_AD, 3'd0, 3'd0, 2'd0), "br"};
    vecs[19] = '{1'b1, 6'b010001, pk(F_UNC | F_RW | F_RS | F_DPC, 3'd0, 3'd0, 2'd0), "bl"};
    vecs[20] = '{1'b1, 6'b010010, pk(9'h0, 3'd1, 3'd0, 2'd0), "bltz"};
    vecs[21] = '{1'b1, 6'b010011, pk(9'h0, 3'd2, 3'd0, 2'd0), "bz"};
    vecs[22] = '{1'b1, 6'b010100, pk(9'h0, 3'd3, 3'd0, 2'd0), "bnz"};
    vecs[23] = '{1'b1, 6'b010101, pk(9'h0, 3'd4, 3'd0, 2'd0), "bcy"};
    vecs[24] = '{1'b1, 6'b010110, pk(9'h0, 3'd5, 3'd0, 2'd0), "bncy"};
    vecs[25] = '{1'b1, 6'b101010, pk(9'h0, 3'd0, 3'd0, 2'd0), "nop_101010"};
    vecs[26] = '{1'b1, 6'b010111, pk(9'h0, 3'd0, 3'd0, 2'd0), "nop_010111"};

    #2;
    check("reset_state_t0", '0);

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      reset  = vecs[i].rst;
      opcode = vecs[i].op;
      #2;
      check(vecs[i].name, vecs[i].exp);
    end

    // Halt latches on a clock edge and survives later opcodes.
    @(negedge clk);
    reset  = 1'b1;
    opcode = 6'b111111;
    #2 check("halt_comb", pk(F_HLT, 3'd0, 3'd0, 2'd0));
    @(negedge clk);
    opcode = 6'b000000;
    #2 check("halt_hold_add", pk(F_RW | F_HLT, 3'd0, 3'd0, 2'd0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      opcode = 6'b001101;
      #2 check("halt_hold_lw", pk(F_RW | F_MR | F_MTR | F_HLT, 3'd0, 3'd0, 2'd1));
    end
    // Asynchronous clear, no clock edge in between.
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check("halt_async_clr", '0);
    #1 reset = 1'b1;
    opcode = 6'b000000;
    #1 check("post_reset_no_halt", pk(F_RW, 3'd0, 3'd0, 2'd0));
    @(posedge clk);
    #1 check("halt_stays_clear", pk(F_RW, 3'd0, 3'd0, 2'd0));
    // HALT opcode under reset is masked; after release it shows combinationally
    // but does not latch if it goes away before the edge.
    @(negedge clk);
    reset  = 1'b0;
    opcode = 6'b111111;
    #1 check("rst_masks_halt", '0);
    #1 reset = 1'b1;
    #1 check("halt_after_release", pk(F_HLT, 3'd0, 3'd0, 2'd0));
    opcode = 6'b000000;
    #1 check("halt_not_latched", pk(F_RW, 3'd0, 3'd0, 2'd0));
    @(posedge clk);
    #1 check("halt_not_latched_edge", pk(F_RW, 3'd0, 3'd0, 2'd0));

    // Randomized run against the reference model.
    mh = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 15) != 0);
      opcode = ($urandom_range(0, 19) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
      if (!reset) mh = 1'b0;
      #2;
      check("random", model_out(reset, opcode));
      tests++;
      if ((MemRead && MemWrite) || (unconditional && conditional != 3'd0)) begin
        fails++;
        $display("FAIL exclusive: opcode=%b mr=%b mw=%b unc=%b cond=%b required no overlap",
                 opcode, MemRead, MemWrite, unconditional, conditional);
      end
      @(posedge clk);
      if (reset && opcode == 6'h3F) mh = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
